// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the sequential ALU.
// ALU_MUL_EN controls whether MUL is treated as a multi-cycle operation.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_SAR   = 4'd8,
    OP_ROL   = 4'd9,
    OP_ROR   = 4'd10,
    OP_INC   = 4'd11,
    OP_DEC   = 4'd12,
    OP_CMP   = 4'd13,
    OP_MUL   = 4'd14,
    OP_PASSB = 4'd15
  } aluOp_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL,
    DONE
  } aluState_e;

  function automatic logic isShift(aluOp_e op);
    return op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR};
  endfunction

  function automatic logic isMultiCycle(aluOp_e op);
`ifdef ALU_MUL_EN
    return isShift(op) || (op == OP_MUL);
`else
    return isShift(op);
`endif
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier.
// Bit 0 of the multiplier is consumed on the start edge, the remaining
// WIDTH-1 bits on the following edges; busy drops once the product is final.
module alu_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // Load operands (folding in multiplier bit 0), then add-and-shift one bit per cycle
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_q <= b >> 1;
      cnt_q    <= CW'(WIDTH - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Shifts iterate one bit per cycle; MUL exists only when ALU_MUL_EN is
// defined, otherwise opCode 14 completes at once and flags illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       opCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aOut,
  output logic             overFlow,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  aluState_e        state_q, state_d;
  aluOp_e           op_q, opIn;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] aOut_q;
  logic             overFlow_q, carry_q, zero_q, negative_q, illegal_q;

  logic             accept;
  logic [SHW-1:0]   shAmt;
  logic [WIDTH:0]   sum, diff, incRes, decRes;
  logic [WIDTH-1:0] res;
  logic             resV, resC, resZ, resN, resIll;
  logic [WIDTH-1:0] shNext;
  logic             shOut;

  assign opIn   = aluOp_e'(opCode);
  assign shAmt  = b[SHW-1:0];
  assign accept = inValid && inReady;

`ifdef ALU_MUL_EN
  logic               mulStart, mulBusy;
  logic [2*WIDTH-1:0] product;

  assign mulStart = accept && (opIn == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) uMul (
    .clk     (clk),
    .rstN    (rstN),
    .start   (mulStart),
    .a       (a),
    .b       (b),
    .busy    (mulBusy),
    .product (product)
  );
`endif

  // Single-cycle result and flags straight from the input operands
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    incRes = {1'b0, a} + (WIDTH+1)'(1);
    decRes = {1'b0, a} - (WIDTH+1)'(1);
    res    = a;
    resC   = 1'b0;
    resV   = 1'b0;
    resIll = 1'b0;
    case (opIn)
      OP_ADD: begin
        res  = sum[MSB:0];
        resC = sum[WIDTH];
        resV = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res  = (opIn == OP_SUB) ? diff[MSB:0] : a;
        resC = diff[WIDTH];
        resV = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT:   res = ~a;
      OP_PASSB: res = b;
      OP_INC: begin
        res  = incRes[MSB:0];
        resC = incRes[WIDTH];
        resV = !a[MSB] && incRes[MSB];
      end
      OP_DEC: begin
        res  = decRes[MSB:0];
        resC = decRes[WIDTH];
        resV = a[MSB] && !decRes[MSB];
      end
      OP_MUL: begin
        res = '0;
`ifndef ALU_MUL_EN
        resIll = 1'b1;
`endif
      end
      default: res = a;
    endcase
    resZ = (res == '0);
    resN = res[MSB];
    if (opIn == OP_CMP) begin
      resZ = (diff[MSB:0] == '0);
      resN = diff[MSB];
    end
    if (resIll) begin
      resZ = 1'b0;
      resN = 1'b0;
    end
  end

  // One-bit shift/rotate step on the working register
  always_comb begin
    shNext = work_q;
    shOut  = 1'b0;
    case (op_q)
      OP_SHL: begin shOut = work_q[MSB]; shNext = {work_q[MSB-1:0], 1'b0};        end
      OP_SHR: begin shOut = work_q[0];   shNext = {1'b0, work_q[MSB:1]};          end
      OP_SAR: begin shOut = work_q[0];   shNext = {work_q[MSB], work_q[MSB:1]};   end
      OP_ROL: begin shOut = work_q[MSB]; shNext = {work_q[MSB-1:0], work_q[MSB]}; end
      OP_ROR: begin shOut = work_q[0];   shNext = {work_q[0], work_q[MSB:1]};     end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: zero-amount shifts complete immediately like logic ops
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (isMultiCycle(opIn) && !(isShift(opIn) && shAmt == '0))
            state_d = isShift(opIn) ? SHIFT : MUL;
          else
            state_d = DONE;
        end
      end
      SHIFT: if (cnt_q == SHW'(1)) state_d = DONE;
      MUL: begin
`ifdef ALU_MUL_EN
        if (!mulBusy) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: if (outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from the current state
  always_comb begin
    inReady  = (state_q == IDLE);
    outValid = (state_q == DONE);
  end

  // Operand latching, shift iteration and result/flag capture on entry to DONE
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op_q       <= OP_ADD;
      work_q     <= '0;
      cnt_q      <= '0;
      aOut_q     <= '0;
      overFlow_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= opIn;
            work_q <= a;
            cnt_q  <= shAmt;
            if (state_d == DONE) begin
              aOut_q     <= res;
              overFlow_q <= resV;
              carry_q    <= resC;
              zero_q     <= resZ;
              negative_q <= resN;
              illegal_q  <= resIll;
            end
          end
        end
        SHIFT: begin
          work_q <= shNext;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            aOut_q     <= shNext;
            overFlow_q <= 1'b0;
            carry_q    <= shOut;
            zero_q     <= (shNext == '0);
            negative_q <= shNext[MSB];
            illegal_q  <= 1'b0;
          end
        end
        MUL: begin
`ifdef ALU_MUL_EN
          if (!mulBusy) begin
            aOut_q     <= product[MSB:0];
            overFlow_q <= |product[2*WIDTH-1:WIDTH];
            carry_q    <= 1'b0;
            zero_q     <= (product[MSB:0] == '0);
            negative_q <= product[MSB];
            illegal_q  <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign aOut     = aOut_q;
  assign overFlow = overFlow_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, scoreboard-based bench for alu_seq at WIDTH=4.
// The MUL checks follow ALU_MUL_EN, matching whichever build is compiled.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [3:0]   opCode = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [W-1:0] aOut;
  logic         overFlow, carry, zero, negative, illegal;

  typedef struct {
    logic [W-1:0] aOut;
    logic         ov, c, z, n, ill;
    int           lat;
  } expT;

  expT sb[$];
  int  passCount = 0;
  int  totalCount = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .inValid  (inValid),
    .inReady  (inReady),
    .opCode   (opCode),
    .a        (a),
    .b        (b),
    .outValid (outValid),
    .outReady (outReady),
    .aOut     (aOut),
    .overFlow (overFlow),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .illegal  (illegal)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic expT mk(logic [W-1:0] r, logic ov, logic c, logic z,
                             logic n, logic ill, int lat);
    expT e;
    e.aOut = r; e.ov = ov; e.c = c; e.z = z; e.n = n; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  task automatic checkFlags(string name, expT e);
    chk({name, ".aOut"},     aOut,     e.aOut);
    chk({name, ".overFlow"}, overFlow, e.ov);
    chk({name, ".carry"},    carry,    e.c);
    chk({name, ".zero"},     zero,     e.z);
    chk({name, ".negative"}, negative, e.n);
    chk({name, ".illegal"},  illegal,  e.ill);
  endtask

  task automatic applyStimulus(aluOp_e op, logic [W-1:0] av, logic [W-1:0] bv, expT e);
    @(negedge clk);
    chk("inReadyBeforeAccept", inReady, 1);
    inValid = 1'b1;
    opCode  = op;
    a       = av;
    b       = bv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    opCode  = 4'($urandom);
    a       = W'($urandom);
    b       = W'($urandom);
  endtask

  task automatic checkOutput(string name, int holdCycles);
    expT e;
    int  lat;
    lat = 1;
    while (outValid !== 1'b1 && lat < 64) begin
      chk({name, ".inReadyBusy"}, inReady, 0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, ".outValid"}, outValid, 1);
    chk({name, ".sbDepth"}, sb.size(), 1);
    e = mk('0, 0, 0, 0, 0, 0, 0);
    if (sb.size() > 0) e = sb.pop_front();
    chk({name, ".latency"}, lat, e.lat);
    checkFlags(name, e);
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
      chk({name, ".holdValid"}, outValid, 1);
      chk({name, ".holdInReady"}, inReady, 0);
      checkFlags({name, ".hold"}, e);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    chk({name, ".idleValid"}, outValid, 0);
    chk({name, ".idleInReady"}, inReady, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.inReady", inReady, 1);
    chk("rst.outValid", outValid, 0);
    checkFlags("rst", mk('0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(OP_ADD, 4'd7, 4'd1, mk(4'd8, 1, 0, 0, 1, 0, 1));
    checkOutput("add7_1", 0);
    applyStimulus(OP_ADD, 4'b1000, 4'b1000, mk(4'd0, 1, 1, 1, 0, 0, 1));
    checkOutput("add8_8", 0);
    applyStimulus(OP_SUB, 4'd2, 4'd5, mk(4'd13, 0, 1, 0, 1, 0, 1));
    checkOutput("sub2_5", 0);
    applyStimulus(OP_CMP, 4'd3, 4'd3, mk(4'd3, 0, 0, 1, 0, 0, 1));
    checkOutput("cmp3_3", 0);
    applyStimulus(OP_AND, 4'b1100, 4'b1010, mk(4'b1000, 0, 0, 0, 1, 0, 1));
    checkOutput("and", 0);
    applyStimulus(OP_OR, 4'b0000, 4'b0000, mk(4'b0000, 0, 0, 1, 0, 0, 1));
    checkOutput("or0", 0);
    applyStimulus(OP_XOR, 4'b1100, 4'b1010, mk(4'b0110, 0, 0, 0, 0, 0, 1));
    checkOutput("xor", 0);
    applyStimulus(OP_NOT, 4'b0101, 4'b0000, mk(4'b1010, 0, 0, 0, 1, 0, 1));
    checkOutput("not", 0);
    applyStimulus(OP_INC, 4'b1111, 4'd0, mk(4'd0, 0, 1, 1, 0, 0, 1));
    checkOutput("inc15", 0);
    applyStimulus(OP_DEC, 4'b1000, 4'd0, mk(4'b0111, 1, 0, 0, 0, 0, 1));
    checkOutput("dec8", 0);
    applyStimulus(OP_DEC, 4'b0000, 4'd0, mk(4'b1111, 0, 1, 0, 1, 0, 1));
    checkOutput("dec0", 0);
    applyStimulus(OP_PASSB, 4'd9, 4'd5, mk(4'd5, 0, 0, 0, 0, 0, 1));
    checkOutput("passb", 0);

    applyStimulus(OP_SHL, 4'b1011, 4'd3, mk(4'b1000, 0, 1, 0, 1, 0, 4));
    checkOutput("shl3", 0);
    applyStimulus(OP_SHL, 4'b1011, 4'd4, mk(4'b1011, 0, 0, 0, 1, 0, 1));
    checkOutput("shl4mod", 0);
    applyStimulus(OP_SHR, 4'b0110, 4'd2, mk(4'b0001, 0, 1, 0, 0, 0, 3));
    checkOutput("shr2", 0);
    applyStimulus(OP_SAR, 4'b1001, 4'd2, mk(4'b1110, 0, 0, 0, 1, 0, 3));
    checkOutput("sar2", 0);
    applyStimulus(OP_ROL, 4'b1000, 4'd1, mk(4'b0001, 0, 1, 0, 0, 0, 2));
    checkOutput("rol1", 0);
    applyStimulus(OP_ROR, 4'b0011, 4'd1, mk(4'b1001, 0, 1, 0, 1, 0, 2));
    checkOutput("ror1", 0);

`ifdef ALU_MUL_EN
    applyStimulus(OP_MUL, 4'd5, 4'd3, mk(4'd15, 0, 0, 0, 1, 0, 5));
    checkOutput("mul5_3", 0);
    applyStimulus(OP_MUL, 4'd6, 4'd3, mk(4'd2, 1, 0, 0, 0, 0, 5));
    checkOutput("mul6_3", 0);
`else
    applyStimulus(OP_MUL, 4'd5, 4'd3, mk(4'd0, 0, 0, 0, 0, 1, 1));
    checkOutput("mulIllegal", 0);
`endif

    outReady = 1'b0;
    applyStimulus(OP_ADD, 4'd3, 4'd4, mk(4'd7, 0, 0, 0, 0, 0, 1));
    checkOutput("backpressure", 5);

    applyStimulus(OP_SHL, 4'b1011, 4'd3, mk(4'b1000, 0, 1, 0, 1, 0, 4));
    @(posedge clk);
    #1;
    chk("abort.inReadyInShift", inReady, 0);
    rstN = 1'b0;
    #1;
    chk("abort.outValid", outValid, 0);
    chk("abort.inReady", inReady, 1);
    checkFlags("abort", mk('0, 0, 0, 0, 0, 0, 0));
    sb.delete();
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("abort.noStale", outValid, 0);
      chk("abort.idleReady", inReady, 1);
    end

    applyStimulus(OP_ADD, 4'd1, 4'd1, mk(4'd2, 0, 0, 0, 0, 0, 1));
    checkOutput("postReset", 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit combinational ALU (opCode/a/b -> aOut/overFlow).
- Datapath width is generic.
- Operands are accepted through a valid/ready handshake.
- Shifts and multiply run as multi-cycle iterative operations.
- Result and full flag set are held until the consumer accepts them.
- Sits between the register file and the writeback stage of the CPU datapath.

Parameters:
WIDTH, 4, operand/result width in bits (>=2).
SHW, $clog2(WIDTH), width of the effective shift-amount field (b[SHW-1:0]).

Ports:
clk  in  1  clock, all state on rising edge.
rstN  in  1  asynchronous active-low reset.
inValid  in  1  operands/opCode present.
inReady  out  1  block can accept an operation.
opCode  in  4  operation select (encoding below).
a  in  WIDTH  operand A.
b  in  WIDTH  operand B / shift amount.
outValid  out  1  result and flags valid.
outReady  in  1  consumer accepts result.
aOut  out  WIDTH  result.
overFlow  out  1  signed overflow (arith) / product truncated (MUL).
carry  out  1  unsigned carry/borrow; last bit shifted out for shifts.
zero  out  1  aOut == 0.
negative  out  1  aOut[WIDTH-1].
illegal  out  1  opCode not implemented in this build.

Behaviour:
- Reset (rstN low, async): state=IDLE, inReady=1 after release, outValid=0, aOut=0, all flags 0. Reset mid-operation aborts the operation; the partial result is discarded.
- Accept: an operation is taken on a clock edge where inValid&&inReady. Operands are latched; the input lines are don't-care afterwards.
- inReady=1 only in IDLE. A stalled DONE blocks new input.
- Opcode map:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a.
  - 6 SHL, 7 SHR logical, 8 SAR, 9 ROL, 10 ROR.
  - 11 INC a, 12 DEC a.
  - 13 CMP: aOut=a, flags from a-b.
  - 14 MUL: low WIDTH bits, unsigned.
  - 15 PASSB.
- Arithmetic rules:
  - carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB/CMP/DEC carry = borrow (1 when a<b unsigned).
  - overFlow = signed overflow.
  - Logic ops clear carry and overFlow.
- FSM:
  - IDLE: on accept, single-cycle ops -> DONE.
    - Shifts with amount 0 -> DONE, result=a, carry=0.
    - Shifts with nonzero amount -> SHIFT.
    - MUL -> MUL.
  - SHIFT: moves one bit per cycle. Counter loads b[SHW-1:0] and decrements; when the counter reaches 1 the state goes -> DONE.
  - MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles -> DONE.
  - DONE: outValid=1. If outReady -> IDLE.
- Latency from accept edge to outValid high:
  - single-cycle ops: 1 cycle.
  - shifts: amount+1 cycles.
  - MUL: WIDTH+1 cycles.
- Outputs are stable throughout DONE until the handshake completes.
- aOut and flags keep their last values in IDLE.
- Shift amount uses b mod WIDTH (b[SHW-1:0]); upper bits are ignored.
- MUL: overFlow=1 if the high WIDTH bits of the 2*WIDTH product are nonzero. carry=0.
- The same-cycle outReady in DONE and inValid are not back-to-back: the new op is accepted on the following IDLE cycle. Throughput is at most one op per 2 cycles.

Optional Feature:
ALU_MUL_EN
- Defined: opCode 14 is implemented as above, using the alu_mul_seq sub-module.
- Undefined: no multiplier logic is built. opCode 14 goes to DONE in 1 cycle with aOut=0, all other flags 0 and illegal=1.
- illegal is 0 for every other opcode in both builds.

Decomposition:
- Package alu_pkg holds:
  - opcode enum aluOp_e (4-bit, values above).
  - FSM enum aluState_e {IDLE, SHIFT, MUL, DONE}.
  - helper function isMultiCycle(op).
- Sub-module alu_mul_seq, WIDTH param:
  - ports: clk, rstN, start, a, b, busy, product[2*WIDTH-1:0].
  - instantiated only under ALU_MUL_EN.

Test Plan (WIDTH=4):
- ADD a=7 b=1, outReady=1 -> outValid 1 cycle after accept, aOut=8, overFlow=1, carry=0, negative=1, zero=0.
- SUB a=2 b=5 -> aOut=13, carry=1 (borrow), overFlow=0. CMP a=3 b=3 -> aOut=3, zero flag reflects the subtraction result 0 (zero=1).
- SHL a=4'b1011 b=3 -> outValid 4 cycles after accept, aOut=4'b1000, carry=1, inReady=0 throughout. SHL b=4 (mod 4=0) -> 1 cycle, aOut=4'b1011.
- MUL a=5 b=3 -> 5 cycles, aOut=15, overFlow=0. MUL a=6 b=3 -> aOut=2, overFlow=1. Without ALU_MUL_EN -> illegal=1, aOut=0.
- Backpressure: ADD result with outReady=0 for 5 cycles -> outValid, aOut and flags held constant, inReady=0. Release outReady -> IDLE next cycle.
- Reset during a SHIFT with b=3 (rstN low in its second cycle) -> outValid=0 and aOut=0 immediately. After release, inReady=1 and no stale result appears.
